// File: rtl/capture_control_pkg.sv
// capture_pkg: shared definitions for the capture-memory controller.
// Holds the capture FSM state type and its raw encodings so host-side
// register logic can decode a state readback without importing the RTL.
package capture_pkg;

  localparam logic [2:0] CAP_ST_IDLE      = 3'd0;
  localparam logic [2:0] CAP_ST_FILL      = 3'd1;
  localparam logic [2:0] CAP_ST_WAIT_TRIG = 3'd2;
  localparam logic [2:0] CAP_ST_POST      = 3'd3;
  localparam logic [2:0] CAP_ST_DONE      = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = CAP_ST_IDLE,
    FILL      = CAP_ST_FILL,
    WAIT_TRIG = CAP_ST_WAIT_TRIG,
    POST      = CAP_ST_POST,
    DONE      = CAP_ST_DONE
  } capture_state_t;

endpackage

// File: rtl/capture_control_ram.sv
// capture_ram: simple dual-port sample buffer, DEPTH x SAMPLE_WIDTH.
// Ports: clock; write port (we, waddr, wdata); synchronous read port
// (re, raddr) with rdata valid one cycle after re. No reset on the array
// or the read register; the parent qualifies rdata.
module capture_ram #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                    clock,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [SAMPLE_WIDTH-1:0] wdata,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [SAMPLE_WIDTH-1:0] rdata
);

  logic [SAMPLE_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/capture_control.sv
// capture_control: circular capture buffer with pre/post-trigger window.
// Inputs : clock, reset_n (async low), arm, valid, dataIn, run,
//          pre_count, post_count, rd_req.
// Outputs: rd_data/rd_valid/rd_last (readout, 1-cycle latency),
//          armed/triggered/done (state flags), trig_addr.
module capture_control
  import capture_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 8,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    arm,
  input  logic                    valid,
  input  logic [SAMPLE_WIDTH-1:0] dataIn,
  input  logic                    run,
  input  logic [ADDR_WIDTH-1:0]   pre_count,
  input  logic [ADDR_WIDTH-1:0]   post_count,
  input  logic                    rd_req,
  output logic [SAMPLE_WIDTH-1:0] rd_data,
  output logic                    rd_valid,
  output logic                    rd_last,
  output logic                    armed,
  output logic                    triggered,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   trig_addr
);

  localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   C_ONE = 1;

  capture_state_t state, next_state;

  logic [ADDR_WIDTH-1:0]   wr_ptr, rd_ptr, fill_cnt, post_rem, pre_q, post_q;
  logic [ADDR_WIDTH:0]     rd_cnt, win_size;
  logic [ADDR_WIDTH-1:0]   post_max;
  logic                    wr_en, rd_acc, trig_hit;
  logic [SAMPLE_WIDTH-1:0] ram_q;

  // DEPTH-1-pre_count is just the bitwise complement.
  assign post_max = ~pre_count;
  assign win_size = {1'b0, pre_q} + {1'b0, post_q} + C_ONE;
  assign trig_hit = (state == WAIT_TRIG) && valid && run && !arm;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    rd_acc     = 1'b0;
    if (arm) begin
      next_state = (pre_count == '0) ? WAIT_TRIG : FILL;
    end else begin
      case (state)
        FILL: begin
          wr_en = valid;
          if (valid && (fill_cnt + A_ONE == pre_q)) next_state = WAIT_TRIG;
        end
        WAIT_TRIG: begin
          wr_en = valid;
          if (valid && run) next_state = (post_q == '0) ? DONE : POST;
        end
        POST: begin
          wr_en = valid;
          if (valid && post_rem == A_ONE) next_state = DONE;
        end
        DONE:    rd_acc = rd_req && (rd_cnt != win_size);
        default: next_state = state;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill_cnt  <= '0;
      post_rem  <= '0;
      pre_q     <= '0;
      post_q    <= '0;
      rd_cnt    <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      trig_addr <= '0;
    end else if (arm) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill_cnt  <= '0;
      post_rem  <= '0;
      rd_cnt    <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      trig_addr <= '0;
      pre_q     <= pre_count;
      post_q    <= (post_count > post_max) ? post_max : post_count;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + A_ONE;
      if (state == FILL && valid) fill_cnt <= fill_cnt + A_ONE;
      if (state == POST && valid) post_rem <= post_rem - A_ONE;
      // The trigger sample lands at wr_ptr, so the window start is known
      // now and readout can begin straight away once DONE is reached.
      if (trig_hit) begin
        trig_addr <= wr_ptr;
        post_rem  <= post_q;
        rd_ptr    <= wr_ptr - pre_q;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + A_ONE;
        rd_cnt <= rd_cnt + C_ONE;
      end
      rd_valid <= rd_acc;
      rd_last  <= rd_acc && (rd_cnt + C_ONE == win_size);
    end
  end

  // The RAM read register has no reset; zero rd_data whenever it is not valid.
  assign rd_data   = rd_valid ? ram_q : '0;
  assign armed     = (state == FILL) || (state == WAIT_TRIG) || (state == POST);
  assign triggered = (state == POST) || (state == DONE);
  assign done      = (state == DONE);

  capture_ram #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_ram (
    .clock (clock),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (dataIn),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_capture_control.sv
module tb_capture_control;
  import capture_pkg::*;

  localparam int SW = 8;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          arm = 1'b0, valid = 1'b0, run = 1'b0, rd_req = 1'b0;
  logic [SW-1:0] dataIn = '0;
  logic [AW-1:0] pre_count = '0, post_count = '0;
  logic [SW-1:0] rd_data;
  logic          rd_valid, rd_last, armed, triggered, done;
  logic [AW-1:0] trig_addr;

  capture_control #(.SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset_n(reset_n), .arm(arm), .valid(valid),
    .dataIn(dataIn), .run(run), .pre_count(pre_count),
    .post_count(post_count), .rd_req(rd_req), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_last(rd_last), .armed(armed),
    .triggered(triggered), .done(done), .trig_addr(trig_addr)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [AW-1:0] pre, post;
    int            ntrig;      // samples before the trigger sample
    int            npost;      // post samples expected before done
    logic [SW-1:0] base;       // sample i carries base+i
    logic          run_fill;   // pulse run with the first FILL sample
    logic [AW-1:0] exp_trig;
    logic [SW-1:0] exp_first;
    int            exp_win;
  } scen_t;

  scen_t tbl [5];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_scen(input scen_t s, input string tag, input bit do_read);
    arm = 1'b1; pre_count = s.pre; post_count = s.post;
    step();
    arm = 1'b0;
    chk({tag, ".armed"}, 32'(armed), 1);
    chk({tag, ".trig0"}, 32'(triggered), 0);
    for (int i = 0; i < s.ntrig; i++) begin
      valid = 1'b1; dataIn = s.base + SW'(i);
      run = s.run_fill && (i == 0);
      step();
      chk({tag, ".no_trig_early"}, 32'(triggered), 0);
    end
    valid = 1'b1; run = 1'b1; dataIn = s.base + SW'(s.ntrig);
    step();
    run = 1'b0;
    chk({tag, ".triggered"}, 32'(triggered), 1);
    chk({tag, ".trig_addr"}, 32'(trig_addr), 32'(s.exp_trig));
    chk({tag, ".done_at_trig"}, 32'(done), 32'(s.npost == 0));
    for (int j = 0; j < s.npost; j++) begin
      dataIn = s.base + SW'(s.ntrig + 1 + j);
      step();
      chk($sformatf("%s.done_post%0d", tag, j), 32'(done), 32'(j == s.npost - 1));
    end
    valid = 1'b0;
    chk({tag, ".armed_off"}, 32'(armed), 0);
    if (do_read) begin
      for (int k = 0; k < s.exp_win; k++) begin
        rd_req = 1'b1;
        step();
        chk($sformatf("%s.rv%0d", tag, k), 32'(rd_valid), 1);
        chk($sformatf("%s.rd%0d", tag, k), 32'(rd_data), 32'(s.exp_first + SW'(k)));
        chk($sformatf("%s.rl%0d", tag, k), 32'(rd_last), 32'(k == s.exp_win - 1));
      end
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      chk({tag, ".exhausted"}, 32'(rd_valid), 0);
    end
  endtask

  initial begin
    //              pre post ntrig npost base  rf  trig first win
    tbl[0] = '{4'd4,  4'd3,  10, 3, 8'h00, 1'b0, 4'd10, 8'h06,  8};  // basic
    tbl[1] = '{4'd0,  4'd0,   0, 0, 8'h55, 1'b0, 4'd0,  8'h55,  1};  // zero counts
    tbl[2] = '{4'd5,  4'd4,  19, 4, 8'h00, 1'b0, 4'd3,  8'h0E, 10};  // wrap-around
    tbl[3] = '{4'd10, 4'd15, 10, 5, 8'h30, 1'b1, 4'd10, 8'h30, 16};  // clamp + FILL run
    tbl[4] = '{4'd0,  4'd1,   0, 1, 8'hB0, 1'b0, 4'd0,  8'hB0,  2};  // after re-arm

    #12;
    chk("reset.outs", {rd_data, rd_valid, rd_last, armed, triggered, done, trig_addr}, 0);
    chk("reset.state", 32'(dut.state), 32'(IDLE));
    reset_n = 1'b1;
    step();
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    chk("idle.rd_ignored", 32'(rd_valid), 0);

    run_scen(tbl[0], "basic", 1'b1);
    run_scen(tbl[1], "zero", 1'b1);
    run_scen(tbl[2], "wrap", 1'b1);
    run_scen(tbl[3], "clamp", 1'b1);

    // Reset in the middle of POST.
    arm = 1'b1; pre_count = 4'd1; post_count = 4'd3;
    step();
    arm = 1'b0;
    valid = 1'b1; dataIn = 8'h11; step();
    run = 1'b1;   dataIn = 8'h12; step();
    run = 1'b0;   dataIn = 8'h13; step();
    valid = 1'b0;
    chk("post.triggered", 32'(triggered), 1);
    chk("post.done", 32'(done), 0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_post.outs", {rd_data, rd_valid, rd_last, armed, triggered, done, trig_addr}, 0);
    chk("rst_post.state", 32'(dut.state), 32'(IDLE));
    step();
    reset_n = 1'b1;
    step();

    // Re-arm while reading out: request in the arm cycle is dropped.
    run_scen('{4'd1, 4'd1, 1, 1, 8'hA0, 1'b0, 4'd1, 8'hA0, 3}, "pre_rearm", 1'b0);
    rd_req = 1'b1;
    step();
    chk("rearm.rv_before", 32'(rd_valid), 1);
    chk("rearm.rd_before", 32'(rd_data), 32'h A0);
    arm = 1'b1; pre_count = 4'd0; post_count = 4'd1;
    step();
    arm = 1'b0; rd_req = 1'b0;
    chk("rearm.rv_dropped", 32'(rd_valid), 0);
    chk("rearm.done_clr", 32'(done), 0);
    run_scen(tbl[4], "rearm", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
